multi_motor_ctrl: RTL

- Parametrised N-channel H-bridge motor controller.
- Per channel it provides sign-magnitude PWM drive (hb_ena/hb_dir), a quadrature encoder speed meter, and a selectable command source: off, external velocity, or an internal triangle sweep.
- Successor to the fixed two-channel drive/encoder/triangle arrangement; instantiated once at top level, with the top-level LED/debug logic reading the speed outputs.

---
 rtl/multi_motor_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/multi_motor_ctrl.sv
// N-channel sign-magnitude H-bridge PWM driver with quadrature speed metering and a shared triangle sweep.
// Stall detection is compiled in only when STALL_DETECT_EN is defined; otherwise stall is tied low.
module multi_motor_ctrl #(
  parameter int NCH           = 2,
  parameter int W             = 8,
  parameter int WIN_CYCLES    = 1000000,
  parameter int TRI_DIV       = 4096,
  parameter int STALL_MIN     = 32,
  parameter int STALL_WINDOWS = 4
) (
  input  logic             cclk,
  input  logic             rstb,
  input  logic [2*NCH-1:0] mode,
  input  logic [NCH*W-1:0] velocity,
  input  logic [NCH-1:0]   enc_a,
  input  logic [NCH-1:0]   enc_b,
  output logic [NCH-1:0]   hb_ena,
  output logic [NCH-1:0]   hb_dir,
  output logic [NCH*W-1:0] speed,
  output logic             speed_valid,
  output logic [NCH-1:0]   stall
);
  localparam int MAXM = 2**(W-1) - 1;
  localparam int PW   = W - 1;
  localparam int AW   = $clog2(WIN_CYCLES + 1) + 1;
  localparam int CW   = ((AW > W) ? AW : W) + 1;
  localparam int WCW  = $clog2(WIN_CYCLES);
  localparam int TCW  = (TRI_DIV > 1) ? $clog2(TRI_DIV) : 1;

  localparam logic [PW-1:0]        PWM_LAST = PW'(MAXM - 1);
  localparam logic signed [W-1:0]  VAL_MAX  = W'(MAXM);
  localparam logic signed [W-1:0]  VAL_NEG  = W'(-MAXM);
  localparam logic signed [W-1:0]  VAL_MIN  = W'(-MAXM - 1);
  localparam logic signed [CW-1:0] SAT_HI   = CW'(MAXM);
  localparam logic signed [CW-1:0] SAT_LO   = CW'(-MAXM - 1);

  if (NCH < 1 || NCH > 8 || W < 4 || W > 16 || WIN_CYCLES < 4 || TRI_DIV < 1 ||
      STALL_WINDOWS < 1 || STALL_MIN < 0) begin : g_bad_params
    $error("multi_motor_ctrl: parameter out of range");
  end

  logic [PW-1:0]       pwm_cnt;
  logic                wrap;
  logic [WCW-1:0]      win_cnt;
  logic                win_end;
  logic signed [W-1:0] tri_val;
  logic                tri_up;
  logic [TCW-1:0]      tri_div;
  logic                tri_step;

  assign wrap     = (pwm_cnt == PWM_LAST);
  assign win_end  = (win_cnt == WCW'(WIN_CYCLES - 1));
  assign tri_step = (tri_div == TCW'(TRI_DIV - 1));

  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    case (g)
      2'b00:   gray_pos = 2'd0;
      2'b01:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  always_ff @(posedge cclk or posedge rstb) begin
    if (rstb) begin
      pwm_cnt     <= '0;
      win_cnt     <= '0;
      speed_valid <= 1'b0;
    end else begin
      pwm_cnt     <= wrap ? '0 : pwm_cnt + 1'b1;
      win_cnt     <= win_end ? '0 : win_cnt + 1'b1;
      speed_valid <= win_end;
    end
  end

  // Each endpoint is reached once and left on the following step, so no value is held twice.
  always_ff @(posedge cclk or posedge rstb) begin
    if (rstb) begin
      tri_val <= '0;
      tri_up  <= 1'b1;
      tri_div <= '0;
    end else begin
      tri_div <= tri_step ? '0 : tri_div + 1'b1;
      if (tri_step) begin
        if (tri_up) begin
          if (tri_val == VAL_MAX) begin
            tri_val <= tri_val - 1'b1;
            tri_up  <= 1'b0;
          end else begin
            tri_val <= tri_val + 1'b1;
          end
        end else begin
          if (tri_val == VAL_NEG) begin
            tri_val <= tri_val + 1'b1;
            tri_up  <= 1'b1;
          end else begin
            tri_val <= tri_val - 1'b1;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [1:0]           m;
    logic                 active;
    logic signed [W-1:0]  cmd;
    logic [W-1:0]         cmd_neg;
    logic [PW-1:0]        cmd_mag;
    logic [PW-1:0]        mag;
    logic                 dir;
    logic                 ena_q;
    logic                 dir_q;
    logic [1:0]           sync1;
    logic [1:0]           sync2;
    logic [1:0]           prev_ab;
    logic [1:0]           diff;
    logic signed [AW-1:0] step;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic signed [CW-1:0] sum_x;
    logic signed [W-1:0]  sat_val;
    logic signed [W-1:0]  speed_q;
    logic                 stall_q;

    assign m       = mode[2*i +: 2];
    assign active  = (m == 2'b01) || (m == 2'b10);
    assign cmd     = (m == 2'b10) ? tri_val : velocity[W*i +: W];
    assign cmd_neg = -cmd;
    assign cmd_mag = (cmd == VAL_MIN) ? PW'(MAXM) :
                     (cmd[W-1] ? cmd_neg[PW-1:0] : cmd[PW-1:0]);

    // Position difference mod 4: +1 forward, 3 reverse, 0 idle, 2 both phases flipped (ignored).
    assign diff = gray_pos(sync2) - gray_pos(prev_ab);
    always_comb begin
      step = '0;
      if (diff == 2'd1)
        step = {{(AW-1){1'b0}}, 1'b1};
      else if (diff == 2'd3)
        step = '1;
    end

    assign sum   = acc + step;
    assign sum_x = CW'(sum);
    always_comb begin
      sat_val = sum_x[W-1:0];
      if (sum_x > SAT_HI)
        sat_val = VAL_MAX;
      else if (sum_x < SAT_LO)
        sat_val = VAL_MIN;
    end

    always_ff @(posedge cclk or posedge rstb) begin
      if (rstb) begin
        sync1   <= '0;
        sync2   <= '0;
        prev_ab <= '0;
        acc     <= '0;
        speed_q <= '0;
      end else begin
        sync1   <= {enc_a[i], enc_b[i]};
        sync2   <= sync1;
        prev_ab <= sync2;
        if (win_end) begin
          acc     <= '0;
          speed_q <= sat_val;
        end else begin
          acc     <= sum;
        end
      end
    end

    // Off clears immediately; a new command is only picked up on the period wrap.
    always_ff @(posedge cclk or posedge rstb) begin
      if (rstb) begin
        mag   <= '0;
        dir   <= 1'b0;
        ena_q <= 1'b0;
        dir_q <= 1'b0;
      end else begin
        if (!active) begin
          mag <= '0;
          dir <= 1'b0;
        end else if (wrap) begin
          mag <= cmd_mag;
          dir <= cmd[W-1];
        end
        ena_q <= active && !stall_q && (pwm_cnt < mag);
        dir_q <= active && dir;
      end
    end

`ifdef STALL_DETECT_EN
    localparam int SCW = $clog2(STALL_WINDOWS + 1);
    logic [SCW-1:0] stall_cnt;
    logic           stall_hit;

    assign stall_hit = (int'(mag) >= STALL_MIN) && (sat_val == '0);

    always_ff @(posedge cclk or posedge rstb) begin
      if (rstb) begin
        stall_cnt <= '0;
        stall_q   <= 1'b0;
      end else if (!active) begin
        stall_cnt <= '0;
        stall_q   <= 1'b0;
      end else if (win_end) begin
        if (stall_hit) begin
          if (int'(stall_cnt) < STALL_WINDOWS)
            stall_cnt <= stall_cnt + 1'b1;
          if (int'(stall_cnt) + 1 >= STALL_WINDOWS)
            stall_q <= 1'b1;
        end else begin
          stall_cnt <= '0;
        end
      end
    end
`else
    assign stall_q = 1'b0;
`endif

    assign hb_ena[i]       = ena_q;
    assign hb_dir[i]       = dir_q;
    assign speed[W*i +: W] = speed_q;
    assign stall[i]        = stall_q;
  end

endmodule
